// File: rtl/ham_secded_dec_pipe_if.sv
// ham_secded_dec_pipe_if
//  Stream and status bundle between a SECDED decoder and its environment.
//  Signal names are seen from the decoder's side (i_ = into decoder, o_ = out of decoder).
//  Input stream : i_code, i_valid, o_ready
//  Output stream: o_data, o_status, o_err_pos, o_valid, i_ready
//  Statistics   : i_clr_cnt, o_sec_count, o_ded_count
//  HAM_DEC_FATAL_EN: when defined, adds o_fatal (sticky uncorrectable-error halt flag).
//  Modports: slave = decoder, master = environment driving the decoder.
interface ham_secded_dec_pipe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;
    localparam int POS_W        = $clog2(ENCODED_WORD + 2);

    logic [ENCODED_WORD+1:1] i_code;
    logic                    i_valid;
    logic                    o_ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic [1:0]              o_status;
    logic [POS_W-1:0]        o_err_pos;
    logic                    o_valid;
    logic                    i_ready;
    logic                    i_clr_cnt;
    logic [CNT_WIDTH-1:0]    o_sec_count;
    logic [CNT_WIDTH-1:0]    o_ded_count;
`ifdef HAM_DEC_FATAL_EN
    logic                    o_fatal;
`endif

    modport slave (
        input  i_code, i_valid, i_ready, i_clr_cnt,
        output o_ready, o_data, o_status, o_err_pos, o_valid, o_sec_count, o_ded_count
`ifdef HAM_DEC_FATAL_EN
        , output o_fatal
`endif
    );

    modport master (
        output i_code, i_valid, i_ready, i_clr_cnt,
        input  o_ready, o_data, o_status, o_err_pos, o_valid, o_sec_count, o_ded_count
`ifdef HAM_DEC_FATAL_EN
        , input o_fatal
`endif
    );
endinterface

// File: rtl/ham_secded_dec_pipe.sv
// ham_secded_dec_pipe
//  Two-stage pipelined SECDED Hamming decoder with valid/ready flow control.
//  S1 captures the codeword with its syndrome and overall parity; S2 holds the
//  classified, corrected data. Saturating counters track corrected and
//  uncorrectable words at the output handshake.
//  Ports: i_clk (clock), i_rst (synchronous active-high reset),
//         bus (ham_secded_dec_pipe_if.slave: input stream, output stream, statistics).
//  HAM_DEC_FATAL_EN: when defined, the first uncorrectable word leaving the
//  decoder sets a sticky o_fatal that stops intake until reset.
module ham_secded_dec_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic                  i_clk,
    input logic                  i_rst,
    ham_secded_dec_pipe_if.slave bus
);
    localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1;
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS;
    localparam int CW           = ENCODED_WORD + 1;
    localparam int POS_W        = $clog2(ENCODED_WORD + 2);

    localparam logic [1:0] StatClean = 2'b00;
    localparam logic [1:0] StatCorr  = 2'b01;
    localparam logic [1:0] StatUncor = 2'b10;

    // Data occupies the non-power-of-two positions in ascending order.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW:1] c);
        logic [DATA_WIDTH-1:0] d;
        int                    j;
        d = '0;
        j = 0;
        for (int p = 3; p <= ENCODED_WORD; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (j < DATA_WIDTH) d[j] = c[p];
                j++;
            end
        end
        return d;
    endfunction

    logic                   s1_valid;
    logic [CW:1]            s1_code;
    logic [PARITY_BITS-1:0] s1_syn;
    logic                   s1_par;

    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [1:0]             out_status;
    logic [POS_W-1:0]       out_pos;
    logic [CNT_WIDTH-1:0]   sec_cnt;
    logic [CNT_WIDTH-1:0]   ded_cnt;
    logic                   fatal;

    logic                   s2_free, s1_move, in_ready, accept, out_hs;
    logic [PARITY_BITS-1:0] syn_c;
    logic                   par_c;
    logic [CW:1]            fixed;
    logic [DATA_WIDTH-1:0]  dec_data;
    logic [1:0]             dec_status;
    logic [POS_W-1:0]       dec_pos;

    assign s2_free  = !out_valid || bus.i_ready;
    assign s1_move  = s1_valid && s2_free;
    assign in_ready = (!s1_valid || s1_move) && !fatal;
    assign accept   = bus.i_valid && in_ready;
    assign out_hs   = out_valid && bus.i_ready;

    // Syndrome is the XOR of the indices of all set bits in positions 1..ENCODED_WORD.
    always_comb begin
        syn_c = '0;
        for (int p = 1; p <= ENCODED_WORD; p++) begin
            if (bus.i_code[p]) syn_c = syn_c ^ PARITY_BITS'(p);
        end
        par_c = ^bus.i_code;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_code  <= bus.i_code;
            s1_syn   <= syn_c;
            s1_par   <= par_c;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    always_comb begin
        fixed      = s1_code;
        dec_status = StatClean;
        dec_pos    = '0;
        if (s1_par) begin
            if (s1_syn == '0) begin
                // Only the overall parity bit itself flipped.
                dec_status = StatCorr;
                dec_pos    = POS_W'(CW);
            end else if (int'(s1_syn) <= ENCODED_WORD) begin
                dec_status     = StatCorr;
                dec_pos        = POS_W'(s1_syn);
                fixed[s1_syn]  = ~fixed[s1_syn];
            end else begin
                dec_status = StatUncor;
            end
        end else if (s1_syn != '0) begin
            dec_status = StatUncor;
        end
        dec_data = extract(fixed);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_status <= StatClean;
            out_pos    <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= dec_data;
                out_status <= dec_status;
                out_pos    <= dec_pos;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_clr_cnt) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_hs) begin
            if (out_status == StatCorr && sec_cnt != '1) sec_cnt <= sec_cnt + CNT_WIDTH'(1);
            if (out_status == StatUncor && ded_cnt != '1) ded_cnt <= ded_cnt + CNT_WIDTH'(1);
        end
    end

`ifdef HAM_DEC_FATAL_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) fatal <= 1'b0;
        else if (out_hs && out_status == StatUncor) fatal <= 1'b1;
    end
    assign bus.o_fatal = fatal;
`else
    assign fatal = 1'b0;
`endif

    assign bus.o_ready     = in_ready;
    assign bus.o_valid     = out_valid;
    assign bus.o_data      = out_data;
    assign bus.o_status    = out_status;
    assign bus.o_err_pos   = out_pos;
    assign bus.o_sec_count = sec_cnt;
    assign bus.o_ded_count = ded_cnt;
endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
// tb_ham_secded_dec_pipe
//  Directed bench for ham_secded_dec_pipe (DATA_WIDTH=8, CNT_WIDTH=2, 13-bit codeword).
//  A reference encoder and decode model predict each accepted word; a monitor
//  compares every output handshake, counters and stall stability each cycle.
//  HAM_DEC_FATAL_EN: when defined, also exercises the sticky fatal halt.
module tb_ham_secded_dec_pipe;
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] st;
        logic [3:0] pos;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ham_secded_dec_pipe_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) bus ();

    ham_secded_dec_pipe #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int data_pos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

    logic [7:0]  cur_data = 8'h00;
    logic [13:1] cur_mask = '0;
    exp_t        q[$];
    int          sec_m = 0, ded_m = 0;
    logic        fatal_m = 1'b0;
    logic        held_v = 1'b0;
    exp_t        held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [13:1] encode(input logic [7:0] d);
        logic [13:1] c;
        logic        par;
        c = '0;
        for (int i = 0; i < 8; i++) c[data_pos[i]] = d[i];
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 12; p++) if (((p >> k) & 1) == 1) par ^= c[p];
            c[1 << k] = par;
        end
        c[13] = ^c[12:1];
        return c;
    endfunction

    // Expected output from the number and placement of flipped bits.
    function automatic exp_t model(input logic [7:0] d, input logic [13:1] m);
        exp_t e;
        e = '{d: d, st: 2'b00, pos: 4'd0};
        if ($countones(m) == 1) begin
            e.st = 2'b01;
            for (int p = 1; p <= 13; p++) if (m[p]) e.pos = 4'(p);
        end else if ($countones(m) == 2) begin
            e.st = 2'b10;
            for (int i = 0; i < 8; i++) if (m[data_pos[i]]) e.d[i] = ~d[i];
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            sec_m   = 0;
            ded_m   = 0;
            fatal_m = 1'b0;
            held_v  = 1'b0;
        end else begin
            chk("sec_count", 32'(bus.o_sec_count), 32'(sec_m));
            chk("ded_count", 32'(bus.o_ded_count), 32'(ded_m));
`ifdef HAM_DEC_FATAL_EN
            chk("fatal", 32'(bus.o_fatal), 32'(fatal_m));
`endif
            if (held_v)
                chk("stall_hold", {bus.o_valid, bus.o_data, bus.o_status, bus.o_err_pos},
                    {1'b1, held});
            held_v = bus.o_valid && !bus.i_ready;
            held   = '{d: bus.o_data, st: bus.o_status, pos: bus.o_err_pos};
            if (bus.o_valid && bus.i_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(bus.o_data), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("out_word", {bus.o_data, bus.o_status, bus.o_err_pos}, e);
                    if (e.st == 2'b01 && sec_m != 3) sec_m++;
                    if (e.st == 2'b10 && ded_m != 3) ded_m++;
                    if (e.st == 2'b10) fatal_m = 1'b1;
                end
            end
            if (bus.i_clr_cnt) begin
                sec_m = 0;
                ded_m = 0;
            end
            if (bus.i_valid && bus.o_ready) q.push_back(model(cur_data, cur_mask));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [13:1] m);
        cur_data    = d;
        cur_mask    = m;
        bus.i_code  = encode(d) ^ m;
        bus.i_valid = 1'b1;
    endtask

    task automatic do_reset();
        tick();
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", {bus.o_valid, bus.o_ready, bus.o_data, bus.o_status, bus.o_err_pos},
            {1'b0, 1'b1, 8'h00, 2'b00, 4'd0});
    endtask

    // One word through an idle pipe; checks latency and literal output, ends
    // one cycle after the output handshake so counters are settled.
    task automatic send_chk(input logic [7:0] d, input logic [13:1] m, input logic [7:0] ed,
                            input logic [1:0] est, input logic [3:0] epos);
        tick();
        bus.i_ready = 1'b1;
        drive(d, m);
        @(negedge clk);
        chk("in_ready", 32'(bus.o_ready), 32'd1);
        tick();
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.o_valid), 32'd1);
        chk("lit_word", {bus.o_data, bus.o_status, bus.o_err_pos}, {ed, est, epos});
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int n;
        bus.i_code    = '0;
        bus.i_valid   = 1'b0;
        bus.i_ready   = 1'b1;
        bus.i_clr_cnt = 1'b0;

        chk("enc_A5", 32'(encode(8'hA5)), 32'h0A27);
        chk("model_ded", 32'(model(8'hA5, 13'h0024)), {8'hA0, 2'b10, 4'd0});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state", {bus.o_valid, bus.o_ready, bus.o_data, bus.o_status, bus.o_err_pos,
                          bus.o_sec_count, bus.o_ded_count}, {1'b1, 8'h00, 6'd0, 4'd0});

        send_chk(8'hA5, 13'h0000, 8'hA5, 2'b00, 4'd0);
        send_chk(8'hA5, 13'h0010, 8'hA5, 2'b01, 4'd5);
        chk("sec_after_1", 32'(bus.o_sec_count), 32'd1);
        send_chk(8'hA5, 13'h1000, 8'hA5, 2'b01, 4'd13);
        send_chk(8'hA5, 13'h0024, 8'hA0, 2'b10, 4'd0);
        chk("ded_after_1", 32'(bus.o_ded_count), 32'd1);
        chk("sec_unchanged", 32'(bus.o_sec_count), 32'd2);
`ifndef HAM_DEC_FATAL_EN
        chk("ready_after_ded", 32'(bus.o_ready), 32'd1);
`endif
        do_reset();

        // Backpressure: downstream stalls in cycles 3..6 while the source streams.
        idx = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.i_ready = !(c >= 3 && c <= 6);
            if (idx < 6) drive(8'(idx + 1), 13'h0000);
            else bus.i_valid = 1'b0;
            @(negedge clk);
            if (c == 4) chk("bp_ready_low", 32'(bus.o_ready), 32'd0);
            if (bus.i_valid && bus.o_ready) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd6);
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Saturation with a 2-bit counter.
        send_chk(8'h11, 13'h0002, 8'h11, 2'b01, 4'd2);
        send_chk(8'h22, 13'h0100, 8'h22, 2'b01, 4'd9);
        send_chk(8'h33, 13'h0800, 8'h33, 2'b01, 4'd12);
        send_chk(8'h44, 13'h0040, 8'h44, 2'b01, 4'd7);
        send_chk(8'h55, 13'h0008, 8'h55, 2'b01, 4'd4);
        chk("sec_saturated", 32'(bus.o_sec_count), 32'd3);

        // Clear coincident with a corrected-word handshake.
        tick();
        bus.i_ready = 1'b0;
        drive(8'h5A, 13'h0001);
        tick();
        bus.i_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_valid && n < 8);
        chk("clr_wait", 32'(bus.o_valid), 32'd1);
        tick();
        bus.i_ready   = 1'b1;
        bus.i_clr_cnt = 1'b1;
        tick();
        bus.i_clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", 32'(bus.o_sec_count), 32'd0);

        // Reset with two words in flight discards them.
        tick();
        bus.i_ready = 1'b0;
        drive(8'h77, 13'h0000);
        tick();
        drive(8'h88, 13'h0000);
        tick();
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("inflight_valid", 32'(bus.o_valid), 32'd1);
        do_reset();
        bus.i_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("flushed", 32'(bus.o_valid), 32'd0);
        end

`ifdef HAM_DEC_FATAL_EN
        send_chk(8'hA5, 13'h0024, 8'hA0, 2'b10, 4'd0);
        chk("fatal_set", 32'(bus.o_fatal), 32'd1);
        tick();
        drive(8'h3C, 13'h0000);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("fatal_halt", {bus.o_ready, bus.o_valid}, 2'b00);
        end
        do_reset();
        chk("fatal_cleared", 32'(bus.o_fatal), 32'd0);
        send_chk(8'h3C, 13'h0000, 8'h3C, 2'b00, 4'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
